uart_apb_if: RTL and testbench

UART_APB_IF -- requirements
Module: uart_apb_if

---
 rtl/uart_apb_pkg.sv | 26 ++
 rtl/uart_txf.sv | 55 +++++
 rtl/uart_apb_if.sv | 200 ++++++++++++++++++++
 tb/tb_uart_apb_if.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: shared constants for the UART APB register block.
// Register offsets, STATUS bit indices, CFG reset value, feed FSM states.
package uart_apb_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_RXDATA = 4'h4;
   localparam logic [3:0] OFF_CFG    = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam int ST_TXF_FULL   = 0;
   localparam int ST_TXF_EMPTY  = 1;
   localparam int ST_TX_BUSY    = 2;
   localparam int ST_RX_VALID   = 3;
   localparam int ST_RX_OVERRUN = 4;
   localparam int ST_PARITY_ERR = 5;

   localparam logic [4:0] CFG_RST = 5'b00011;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } feed_state_t;

endpackage

// File: rtl/uart_txf.sv
// uart_txf: synchronous byte FIFO with count-based full/empty.
// Head is visible on rdata; pushes when full and pops when empty are ignored.
module uart_txf #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   // storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   // pointers and occupancy count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_apb_if.sv
// uart_apb_if: APB3 register front-end for uart_top with TX FIFO feed FSM.
// Define UART_APB_PSLVERR_EN to flag illegal accesses on pslverr_out.
module uart_apb_if #(
   parameter int TXF_DEPTH = 4,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel_in,
   input  logic              penable_in,
   input  logic              pwrite_in,
   input  logic [ADDR_W-1:0] paddr_in,
   input  logic [31:0]       pwdata_in,
   output logic [31:0]       prdata_out,
   output logic              pready_out,
   output logic              pslverr_out,
   output logic [7:0]        tx_data_out,
   output logic [4:0]        cfg_reg_out,
   output logic              start_tx_out,
   input  logic              tx_busy_in,
   input  logic              tx_done_in,
   input  logic              rx_done_in,
   input  logic              parity_error_in,
   input  logic [7:0]        rx_data_in
);

   import uart_apb_pkg::*;

   feed_state_t state;
   feed_state_t state_nxt;

   logic        access;
   logic        rd_acc;
   logic        wr_acc;
   logic        mapped;
   logic [3:0]  off;
   logic        sel_tx;
   logic        sel_rx;
   logic        sel_cfg;
   logic        sel_st;
   logic        wr_tx;
   logic        wr_cfg;
   logic        wr_st;
   logic        rd_rx;
   logic        push;
   logic        pop;
   logic        txf_full;
   logic        txf_empty;
   logic [7:0]  txf_head;
   logic [7:0]  tx_data;
   logic [4:0]  cfg;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_overrun;
   logic        parity_err;
   logic [31:0] status;
   logic        err_acc;
   logic        unused_bits;

   assign access  = psel_in & penable_in;
   assign rd_acc  = access & ~pwrite_in;
   assign wr_acc  = access & pwrite_in;
   assign off     = {paddr_in[3:2], 2'b00};
   assign mapped  = ((paddr_in >> 4) == '0);
   assign sel_tx  = mapped & (off == OFF_TXDATA);
   assign sel_rx  = mapped & (off == OFF_RXDATA);
   assign sel_cfg = mapped & (off == OFF_CFG);
   assign sel_st  = mapped & (off == OFF_STATUS);
   assign wr_tx   = wr_acc & sel_tx;
   assign wr_cfg  = wr_acc & sel_cfg;
   assign wr_st   = wr_acc & sel_st;
   assign rd_rx   = rd_acc & sel_rx;
   assign push    = wr_tx & ~txf_full;

   assign pready_out   = 1'b1;
   assign tx_data_out  = tx_data;
   assign cfg_reg_out  = cfg;

   uart_txf #(
      .DEPTH (TXF_DEPTH)
   ) u_txf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (pwdata_in[7:0]),
      .pop   (pop),
      .rdata (txf_head),
      .full  (txf_full),
      .empty (txf_empty)
   );

   // feed FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // feed FSM next state, FIFO pop and launch pulse
   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      start_tx_out = 1'b0;
      unique case (state)
         IDLE: begin
            if (!txf_empty && !tx_busy_in) begin
               pop       = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            start_tx_out = 1'b1;
            state_nxt    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy_in) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy_in || tx_done_in) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // launch byte holds until the next pop
   always_ff @(posedge clk) begin
      if (!rst_n)   tx_data <= '0;
      else if (pop) tx_data <= txf_head;
   end

   // line configuration register
   always_ff @(posedge clk) begin
      if (!rst_n)      cfg <= CFG_RST;
      else if (wr_cfg) cfg <= pwdata_in[4:0];
   end

   // receive capture, sticky error flags; set events beat clears
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (rx_done_in) begin
            rx_data  <= rx_data_in;
            rx_valid <= 1'b1;
         end else if (rd_rx) begin
            rx_valid <= 1'b0;
         end
         if (rx_done_in && rx_valid && !rd_rx) begin
            rx_overrun <= 1'b1;
         end else if (wr_st && pwdata_in[ST_RX_OVERRUN]) begin
            rx_overrun <= 1'b0;
         end
         if (rx_done_in && parity_error_in) begin
            parity_err <= 1'b1;
         end else if (wr_st && pwdata_in[ST_PARITY_ERR]) begin
            parity_err <= 1'b0;
         end
      end
   end

   // STATUS word assembly
   always_comb begin
      status                = '0;
      status[ST_TXF_FULL]   = txf_full;
      status[ST_TXF_EMPTY]  = txf_empty;
      status[ST_TX_BUSY]    = tx_busy_in;
      status[ST_RX_VALID]   = rx_valid;
      status[ST_RX_OVERRUN] = rx_overrun;
      status[ST_PARITY_ERR] = parity_err;
   end

   // read mux, driven only during a mapped read access
   always_comb begin
      prdata_out = '0;
      if (rd_acc && mapped) begin
         case (off)
            OFF_RXDATA: prdata_out = {24'b0, rx_data};
            OFF_CFG:    prdata_out = {27'b0, cfg};
            OFF_STATUS: prdata_out = status;
            default:    prdata_out = '0;
         endcase
      end
   end

   assign err_acc = (wr_tx & txf_full)
                  | (wr_acc & sel_rx)
                  | (rd_acc & sel_tx)
                  | (access & ~mapped);

`ifdef UART_APB_PSLVERR_EN
   assign pslverr_out = err_acc;
`else
   assign pslverr_out = 1'b0;
`endif

   assign unused_bits = ^{pwdata_in[31:8], paddr_in[1:0], err_acc};

endmodule

// File: tb/tb_uart_apb_if.sv
// tb_uart_apb_if: self-checking bench for uart_apb_if.
// Register vectors table, TX scoreboard, loopback uart model, corner sequences.
module tb_uart_apb_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [7:0]  tx_data_out;
   logic [4:0]  cfg_reg_out;
   logic        start_tx_out;
   logic        tx_busy_in, tx_done_in, rx_done_in, parity_error_in;
   logic [7:0]  rx_data_in;

   logic        lb_en, lb_busy, lb_done, lb_rx, lb_active;
   logic [7:0]  lb_data;
   logic        man_busy, man_rx, man_par;
   logic [7:0]  man_data;

`ifdef UART_APB_PSLVERR_EN
   localparam logic PERR = 1'b1;
`else
   localparam logic PERR = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int starts = 0;
   logic prev_start = 1'b0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   assign tx_busy_in      = lb_busy | man_busy;
   assign tx_done_in      = lb_done;
   assign rx_done_in      = lb_rx | man_rx;
   assign rx_data_in      = lb_rx ? lb_data : man_data;
   assign parity_error_in = man_par;

   uart_apb_if #(.TXF_DEPTH(4), .ADDR_W(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .psel_in         (psel),
      .penable_in      (penable),
      .pwrite_in       (pwrite),
      .paddr_in        (paddr),
      .pwdata_in       (pwdata),
      .prdata_out      (prdata),
      .pready_out      (pready),
      .pslverr_out     (pslverr),
      .tx_data_out     (tx_data_out),
      .cfg_reg_out     (cfg_reg_out),
      .start_tx_out    (start_tx_out),
      .tx_busy_in      (tx_busy_in),
      .tx_done_in      (tx_done_in),
      .rx_done_in      (rx_done_in),
      .parity_error_in (parity_error_in),
      .rx_data_in      (rx_data_in)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endfunction

   // scoreboard: every launch must carry the next accepted byte
   initial begin
      forever begin
         @(negedge clk);
         if (start_tx_out) begin
            starts++;
            chk("start_one_cycle", 32'(prev_start), 32'd0);
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected_start actual=%h required=none",
                        tx_data_out);
            end else begin
               chk("tx_data", 32'(tx_data_out), 32'(sb_q.pop_front()));
            end
         end
         prev_start = start_tx_out;
      end
   end

   // loopback uart model: busy for 8 cycles, then done + receive
   initial begin
      logic [7:0] b;
      lb_busy = 0; lb_done = 0; lb_rx = 0; lb_data = 0; lb_active = 0;
      forever begin
         @(negedge clk);
         if (start_tx_out && lb_en) begin
            lb_active = 1;
            b = tx_data_out;
            @(posedge clk); #1;
            lb_busy = 1;
            repeat (8) @(posedge clk);
            #1;
            lb_busy = 0; lb_done = 1; lb_rx = 1; lb_data = b;
            @(posedge clk); #1;
            lb_done = 0; lb_rx = 0;
            lb_active = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic apb_x(input logic wr, input logic [3:0] addr,
                        input logic [31:0] data, input logic inj,
                        input logic [7:0] injd, input logic injp,
                        output logic [31:0] rd, output logic err,
                        output logic rdy);
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
      @(posedge clk); #1;
      penable = 1;
      if (inj) begin
         man_rx = 1; man_data = injd; man_par = injp;
      end
      @(negedge clk);
      rd = prdata; err = pslverr; rdy = pready;
      @(posedge clk); #1;
      psel = 0; penable = 0; pwrite = 0;
      man_rx = 0; man_par = 0;
   endtask

   task automatic rd_reg(input logic [3:0] addr, output logic [31:0] rd);
      logic e, r;
      apb_x(1'b0, addr, 32'h0, 1'b0, 8'h0, 1'b0, rd, e, r);
   endtask

   task automatic wr_reg(input logic [3:0] addr, input logic [31:0] d,
                         output logic err);
      logic [31:0] rd;
      logic r;
      apb_x(1'b1, addr, d, 1'b0, 8'h0, 1'b0, rd, err, r);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic accept,
                          output logic err);
      if (accept) sb_q.push_back(b);
      wr_reg(4'h0, {24'h0, b}, err);
   endtask

   task automatic rx_pulse(input logic [7:0] d, input logic p);
      man_rx = 1; man_data = d; man_par = p;
      @(posedge clk); #1;
      man_rx = 0; man_par = 0;
   endtask

   task automatic wait_rx(input string nm);
      logic [31:0] st;
      int n;
      n = 0;
      st = 0;
      while (st[3] == 1'b0 && n < 40) begin
         rd_reg(4'hC, st);
         n++;
      end
      if (st[3] == 1'b0) begin
         total++;
         bad++;
         $display("FAIL %s actual=no_rx_valid required=rx_valid", nm);
      end
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || lb_active) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() != 0 || lb_active) begin
         total++;
         bad++;
         $display("FAIL %s actual=pending=%0d required=0", nm, sb_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   localparam int NV = 14;
   vec_t v[NV];

   initial begin
      logic [31:0] rd;
      logic        err, rdy;
      logic [7:0]  s2[3];
      int          s0, s1;

      v[0]  = '{1'b0, 4'h8, 32'h0,        32'h03, 1'b0};
      v[1]  = '{1'b0, 4'hC, 32'h0,        32'h02, 1'b0};
      v[2]  = '{1'b0, 4'h4, 32'h0,        32'h00, 1'b0};
      v[3]  = '{1'b0, 4'h0, 32'h0,        32'h00, 1'b1};
      v[4]  = '{1'b1, 4'h8, 32'h1F,       32'h00, 1'b0};
      v[5]  = '{1'b0, 4'h8, 32'h0,        32'h1F, 1'b0};
      v[6]  = '{1'b1, 4'h8, 32'hFFFFFFE4, 32'h00, 1'b0};
      v[7]  = '{1'b0, 4'h8, 32'h0,        32'h04, 1'b0};
      v[8]  = '{1'b1, 4'h4, 32'h77,       32'h00, 1'b1};
      v[9]  = '{1'b0, 4'h4, 32'h0,        32'h00, 1'b0};
      v[10] = '{1'b1, 4'hC, 32'hFF,       32'h00, 1'b0};
      v[11] = '{1'b0, 4'hC, 32'h0,        32'h02, 1'b0};
      v[12] = '{1'b1, 4'h8, 32'h03,       32'h00, 1'b0};
      v[13] = '{1'b0, 4'h8, 32'h0,        32'h03, 1'b0};

      rst_n = 0; psel = 0; penable = 0; pwrite = 0;
      paddr = 0; pwdata = 0;
      lb_en = 1; man_busy = 0; man_rx = 0; man_par = 0; man_data = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cfg", 32'(cfg_reg_out), 32'h03);
      chk("rst_txdata", 32'(tx_data_out), 32'h00);
      chk("rst_start", 32'(start_tx_out), 32'h0);
      chk("rst_pready", 32'(pready), 32'h1);
      chk("idle_pslverr", 32'(pslverr), 32'h0);
      chk("idle_prdata", prdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // register vectors
      for (int i = 0; i < NV; i++) begin
         apb_x(v[i].wr, v[i].addr, v[i].wdata, 1'b0, 8'h0, 1'b0,
               rd, err, rdy);
         chk($sformatf("vec%0d_rdata", i), rd, v[i].rd);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].err & PERR));
         chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'h1);
         if (i == 6) chk("cfg_next_cycle", 32'(cfg_reg_out), 32'h04);
      end

      // loopback: three bytes in order
      s2[0] = 8'hA5; s2[1] = 8'h3C; s2[2] = 8'h7E;
      s0 = starts;
      for (int k = 0; k < 3; k++) wr_byte(s2[k], 1'b1, err);
      for (int k = 0; k < 3; k++) begin
         wait_rx($sformatf("s2_wait%0d", k));
         rd_reg(4'h4, rd);
         chk($sformatf("s2_rx%0d", k), rd, 32'(s2[k]));
      end
      wait_drain("s2_drain");
      chk("s2_starts", 32'(starts - s0), 32'd3);

      // FIFO full while uart busy, fifth byte dropped
      man_busy = 1;
      s0 = starts;
      for (int k = 0; k < 4; k++) wr_byte(8'h31 + 8'(k), 1'b1, err);
      rd_reg(4'hC, rd);
      chk("s3_full_status", rd, 32'h05);
      wr_byte(8'h35, 1'b0, err);
      chk("s3_full_err", 32'(err), 32'(PERR));
      rd_reg(4'hC, rd);
      chk("s3_still_full", rd, 32'h05);
      chk("s3_no_start", 32'(starts - s0), 32'd0);
      man_busy = 0;
      wait_drain("s3_drain");
      chk("s3_starts", 32'(starts - s0), 32'd4);
      rd_reg(4'h4, rd);
      chk("s3_last_rx", rd, 32'h34);
      rd_reg(4'hC, rd);
      chk("s3_overrun", rd, 32'h12);
      wr_reg(4'hC, 32'h10, err);
      rd_reg(4'hC, rd);
      chk("s3_clean", rd, 32'h02);

      // overrun without read, W1C clear
      rx_pulse(8'h11, 1'b0);
      rx_pulse(8'h22, 1'b0);
      rd_reg(4'hC, rd);
      chk("s4_status", rd, 32'h1A);
      rd_reg(4'h4, rd);
      chk("s4_rx", rd, 32'h22);
      wr_reg(4'hC, 32'h10, err);
      rd_reg(4'hC, rd);
      chk("s4_cleared", rd, 32'h02);

      // receive in the same cycle as an RXDATA read
      rx_pulse(8'h44, 1'b0);
      apb_x(1'b0, 4'h4, 32'h0, 1'b1, 8'h55, 1'b0, rd, err, rdy);
      chk("s5_old_rx", rd, 32'h44);
      rd_reg(4'hC, rd);
      chk("s5_status", rd, 32'h0A);
      rd_reg(4'h4, rd);
      chk("s5_new_rx", rd, 32'h55);
      rd_reg(4'hC, rd);
      chk("s5_empty", rd, 32'h02);

      // parity flag: set event beats a simultaneous W1C
      rx_pulse(8'h66, 1'b1);
      rd_reg(4'hC, rd);
      chk("par_status", rd, 32'h2A);
      apb_x(1'b1, 4'hC, 32'h20, 1'b1, 8'h67, 1'b1, rd, err, rdy);
      rd_reg(4'hC, rd);
      chk("par_set_wins", rd, 32'h3A);
      wr_reg(4'hC, 32'h30, err);
      rd_reg(4'hC, rd);
      chk("par_cleared", rd, 32'h0A);
      rd_reg(4'h4, rd);
      chk("par_rx", rd, 32'h67);

      // reset during WAIT_DONE with two bytes queued
      lb_en = 0;
      s0 = starts;
      wr_byte(8'h91, 1'b1, err);
      repeat (4) @(posedge clk);
      #1;
      chk("s6_first_start", 32'(starts - s0), 32'd1);
      wr_byte(8'h92, 1'b1, err);
      wr_byte(8'h93, 1'b1, err);
      man_busy = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      man_busy = 0;
      sb_q.delete();
      s1 = starts;
      repeat (20) @(posedge clk);
      #1;
      chk("s6_no_start", 32'(starts - s1), 32'd0);
      chk("s6_txdata", 32'(tx_data_out), 32'h00);
      rd_reg(4'hC, rd);
      chk("s6_status", rd, 32'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
